truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each input vector is held before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a full 16-vector sweep.
REQ-005 SHALL have port abort  input  1  cancel a sweep in progress.
REQ-006 SHALL have ports x, y, w, z  output  1 each  the input vector driven to the C, D, E function modules; x is MSB, z is LSB.
REQ-007 SHALL have ports c, d, e  input  1 each  the function outputs returned from the C, D, E modules.
REQ-008 SHALL have ports tab_c, tab_d, tab_e  output  16 each  captured truth tables; bit i holds the function value for vector index i = {x,y,w,z}.
REQ-009 SHALL have ports cnt_c, cnt_d, cnt_e  output  5 each  number of 1s captured per function (0..16).
REQ-010 SHALL have ports busy (1), done (1) and valid (1), all outputs: sweep active, one-cycle completion pulse, tables complete and stable.

Function
REQ-011 SHALL implement states IDLE, DRIVE, SAMPLE and FIN.
REQ-012 In IDLE, start=1 and abort=0 SHALL load index=0, clear tab_*, cnt_* and valid, and enter DRIVE.
REQ-013 DRIVE SHALL hold {x,y,w,z}=index for exactly SETTLE cycles, then enter SAMPLE.
REQ-014 SAMPLE SHALL last one cycle and write tab_c[index]<=c, tab_d[index]<=d and tab_e[index]<=e.
REQ-015 In the same SAMPLE cycle, each cnt_* SHALL increment by 1 when its sampled input is 1.
REQ-016 From SAMPLE, index<15 SHALL increment index and return to DRIVE; index=15 SHALL enter FIN with no wrap to 0.
REQ-017 FIN SHALL last one cycle, assert done=1, set valid=1 and return to IDLE.
REQ-018 With start sampled high at cycle 0, done SHALL be high at cycle 16*(SETTLE+1)+1.
REQ-019 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and FIN.
REQ-020 start SHALL be ignored while busy=1 or in FIN.
REQ-021 abort=1 in DRIVE or SAMPLE SHALL return to IDLE on the next edge without pulsing done.
REQ-022 An abort SHALL leave valid=0 and SHALL freeze tab_* and cnt_* at their partial values.
REQ-023 In IDLE, simultaneous start and abort SHALL be resolved as abort; no sweep starts.
REQ-024 A SAMPLE cycle with abort=1 SHALL not write tab_* or cnt_*.
REQ-025 In IDLE and FIN, {x,y,w,z} SHALL hold the last driven vector, which is 4'b0000 after reset.
REQ-026 The cnt_* outputs SHALL be 5 bits wide so that a count of 16 does not overflow.
REQ-027 The block SHALL not latch X inputs specially; an X on c, d or e propagates into the table bit.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, index=0, x=y=w=z=0, tab_*=0, cnt_*=0 and busy=done=valid=0.
REQ-029 reset SHALL take priority over start and abort in every state, including mid-sweep.
REQ-030 The first start SHALL be accepted on the first edge where reset=0.

Verification (bench connects the existing C, D, E modules to x, y, w, z and c, d, e; SETTLE=1)
REQ-031 Scenario: reset, then a start pulse.
  -> done at cycle 33.
  -> tab_c=16'hE6B0, tab_d=16'hDB2A, tab_e=16'h7768.
  -> cnt_c=8, cnt_d=9, cnt_e=9.
  -> valid=1, busy=0.
REQ-032 Scenario: start held high continuously through two sweeps.
  -> exactly one done pulse per sweep.
  -> second sweep starts on the edge after FIN.
  -> identical tables from both sweeps.
REQ-033 Scenario: abort at index 5 during DRIVE.
  -> IDLE next cycle, no done, valid=0.
  -> tab_c bits [4:0]=5'b10000, cnt_c=1.
REQ-034 Scenario: reset asserted at index 9.
  -> all outputs 0 next cycle.
  -> a following start gives the full REQ-031 results.
REQ-035 Scenario: start and abort high together in IDLE.
  -> busy stays 0; no state change.
REQ-036 Scenario: SETTLE=3, then start.
  -> done at cycle 65.
  -> each vector held 3 cycles before its SAMPLE cycle.
  -> tables as in REQ-031.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 input vectors through external C/D/E function blocks and
// captures their truth tables plus per-function ones-counts.
//
// state  | meaning
// IDLE   | waiting for start; vector, tables and counts hold their values
// DRIVE  | vector = index held for SETTLE cycles so the functions can settle
// SAMPLE | one cycle: capture c/d/e into table bit [index] and update counts
// FIN    | one cycle: done pulse, valid already set, back to IDLE
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  output logic [15:0] tab_c,
  output logic [15:0] tab_d,
  output logic [15:0] tab_e,
  output logic [4:0]  cnt_c,
  output logic [4:0]  cnt_d,
  output logic [4:0]  cnt_e,
  output logic        busy,
  output logic        done,
  output logic        valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  // Settle timer counts down to zero; loading SETTLE-1 gives exactly SETTLE DRIVE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] index;
  logic [3:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= 4'd0;
      timer <= 4'd0;
      tab_c <= 16'd0;
      tab_d <= 16'd0;
      tab_e <= 16'd0;
      cnt_c <= 5'd0;
      cnt_d <= 5'd0;
      cnt_e <= 5'd0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            index <= 4'd0;
            timer <= SETTLE_LOAD;
            tab_c <= 16'd0;
            tab_d <= 16'd0;
            tab_e <= 16'd0;
            cnt_c <= 5'd0;
            cnt_d <= 5'd0;
            cnt_e <= 5'd0;
            valid <= 1'b0;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
          end else if (timer == 4'd0) begin
            state <= SAMPLE;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            tab_c[index] <= c;
            tab_d[index] <= d;
            tab_e[index] <= e;
            cnt_c <= cnt_c + {4'd0, c};
            cnt_d <= cnt_d + {4'd0, d};
            cnt_e <= cnt_e + {4'd0, e};
            if (index == 4'd15) begin
              // The vector stays at 15 so IDLE keeps showing the last driven value.
              valid <= 1'b1;
              state <= FIN;
            end else begin
              index <= index + 4'd1;
              timer <= SETTLE_LOAD;
              state <= DRIVE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign {x, y, w, z} = index;
  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner; C/D/E functions are modelled as
// 16-entry lookups driven by the scanner's own x/y/w/z outputs.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, start3, abort3;
  logic x, y, w, z, c, d, e;
  logic x3, y3, w3, z3, c3, d3, e3;
  logic [15:0] tab_c, tab_d, tab_e, tab_c3, tab_d3, tab_e3;
  logic [4:0]  cnt_c, cnt_d, cnt_e, cnt_c3, cnt_d3, cnt_e3;
  logic busy, done, valid, busy3, done3, valid3;

  logic [15:0] fn_c = 16'hE6B0;
  logic [15:0] fn_d = 16'hDB2A;
  logic [15:0] fn_e = 16'h7768;

  assign c  = fn_c[{x, y, w, z}];
  assign d  = fn_d[{x, y, w, z}];
  assign e  = fn_e[{x, y, w, z}];
  assign c3 = fn_c[{x3, y3, w3, z3}];
  assign d3 = fn_d[{x3, y3, w3, z3}];
  assign e3 = fn_e[{x3, y3, w3, z3}];

  truth_table_scanner #(.SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x(x), .y(y), .w(w), .z(z), .c(c), .d(d), .e(e),
    .tab_c(tab_c), .tab_d(tab_d), .tab_e(tab_e),
    .cnt_c(cnt_c), .cnt_d(cnt_d), .cnt_e(cnt_e),
    .busy(busy), .done(done), .valid(valid)
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3),
    .x(x3), .y(y3), .w(w3), .z(z3), .c(c3), .d(d3), .e(e3),
    .tab_c(tab_c3), .tab_d(tab_d3), .tab_e(tab_e3),
    .cnt_c(cnt_c3), .cnt_d(cnt_d3), .cnt_e(cnt_e3),
    .busy(busy3), .done(done3), .valid(valid3)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges after the start edge until done is seen; cycle number is n+1.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_full(input string tag);
    chk({tag, "_tab_c"}, 32'(tab_c), 32'h0000E6B0);
    chk({tag, "_tab_d"}, 32'(tab_d), 32'h0000DB2A);
    chk({tag, "_tab_e"}, 32'(tab_e), 32'h00007768);
    chk({tag, "_cnt_c"}, 32'(cnt_c), 32'd8);
    chk({tag, "_cnt_d"}, 32'(cnt_d), 32'd9);
    chk({tag, "_cnt_e"}, 32'(cnt_e), 32'd9);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    repeat (3) tick();

    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_tab_c", 32'(tab_c), 32'd0);
    chk("rst_cnt_e", 32'(cnt_e), 32'd0);
    chk("rst_vec",   32'({x, y, w, z}), 32'd0);

    // Basic sweep, start on the very first edge with reset low.
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy_start", 32'(busy), 32'd1);
    chk("s1_valid_clr",  32'(valid), 32'd0);
    wait_done(n);
    chk("s1_done_cycle", 32'(n + 1), 32'd33);
    chk_full("s1");
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);
    chk("s1_valid_hold", 32'(valid), 32'd1);
    chk("s1_vec_hold",   32'({x, y, w, z}), 32'd15);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    chk("sa_busy0", 32'(busy), 32'd0);
    tick();
    chk("sa_busy1", 32'(busy), 32'd0);
    chk("sa_valid", 32'(valid), 32'd1);
    chk("sa_tab_c", 32'(tab_c), 32'h0000E6B0);
    abort = 1'b0;

    // Start held high across two sweeps.
    tick();
    wait_done(n);
    chk("h1_done_cycle", 32'(n + 1), 32'd33);
    chk_full("h1");
    tick();
    chk("h_fin_exit_busy", 32'(busy), 32'd0);
    chk("h_fin_exit_done", 32'(done), 32'd0);
    tick();
    chk("h2_busy", 32'(busy), 32'd1);
    chk("h2_valid_clr", 32'(valid), 32'd0);
    wait_done(n);
    chk("h2_done_cycle", 32'(n + 1), 32'd33);
    chk_full("h2");
    start = 1'b0;
    tick();
    tick();
    chk("h_after_busy", 32'(busy), 32'd0);

    // Abort while driving index 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("ab_vec5", 32'({x, y, w, z}), 32'd5);
    chk("ab_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy0", 32'(busy), 32'd0);
    chk("ab_done",  32'(done), 32'd0);
    chk("ab_valid", 32'(valid), 32'd0);
    chk("ab_tab_c", 32'(tab_c), 32'h00000010);
    chk("ab_tab_d", 32'(tab_d), 32'h0000000A);
    chk("ab_tab_e", 32'(tab_e), 32'h00000008);
    chk("ab_cnt_c", 32'(cnt_c), 32'd1);
    chk("ab_cnt_d", 32'(cnt_d), 32'd2);
    chk("ab_cnt_e", 32'(cnt_e), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_idle_done", 32'(done), 32'd0);
      chk("ab_idle_busy", 32'(busy), 32'd0);
    end
    chk("ab_tab_c_frozen", 32'(tab_c), 32'h00000010);

    // Reset mid-sweep at index 9.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    chk("rs_vec9", 32'({x, y, w, z}), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_vec",   32'({x, y, w, z}), 32'd0);
    chk("rs_tabs",  32'({tab_c, tab_d}), 32'd0);
    chk("rs_tab_e", 32'(tab_e), 32'd0);
    chk("rs_cnts",  32'({cnt_c, cnt_d, cnt_e}), 32'd0);
    chk("rs_flags", 32'({busy, done, valid}), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("rs_done_cycle", 32'(n + 1), 32'd33);
    chk_full("rs");

    // SETTLE=3 instance: each vector shown for 3 DRIVE cycles plus its SAMPLE cycle.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 300) begin
      chk("st3_vec", 32'({x3, y3, w3, z3}), 32'(n / 4));
      tick();
      n++;
    end
    chk("st3_done_cycle", 32'(n + 1), 32'd65);
    chk("st3_tab_c", 32'(tab_c3), 32'h0000E6B0);
    chk("st3_tab_d", 32'(tab_d3), 32'h0000DB2A);
    chk("st3_tab_e", 32'(tab_e3), 32'h00007768);
    chk("st3_cnts",  32'({cnt_c3, cnt_d3, cnt_e3}), 32'({5'd8, 5'd9, 5'd9}));
    chk("st3_valid", 32'(valid3), 32'd1);
    tick();
    chk("st3_done_pulse", 32'(done3), 32'd0);
    chk("st3_busy", 32'(busy3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
